hippo_mem_ctrl: RTL and testbench

//   Request/response front-end placed directly upstream of hippo_memory.

---
 rtl/hippo_mem_pkg.sv | 30 +++
 rtl/hippo_rsp_fifo.sv | 58 +++++
 rtl/hippo_mem_ctrl.sv | 155 +++++++++++++++
 tb/tb_hippo_mem_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hippo_mem_pkg.sv
// rtl/hippo_mem_pkg.sv - shared types and byte-merge helper for the hippo memory front-end
package hippo_mem_pkg;

   localparam int RSP_DW = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RMW_RD = 2'd1,
      RMW_WR = 2'd2
   } state_e;

   typedef struct packed {
      logic [RSP_DW-1:0] rdata;
      logic              err;
   } rsp_t;

   // Per byte lane: take the new byte where enabled, otherwise keep the old one.
   function automatic logic [RSP_DW-1:0] byte_merge(
      input logic [RSP_DW-1:0]   wr_data,
      input logic [RSP_DW-1:0]   rd_data,
      input logic [RSP_DW/8-1:0] be
   );
      logic [RSP_DW-1:0] res;
      for (int i = 0; i < RSP_DW/8; i++) begin
         res[i*8 +: 8] = be[i] ? wr_data[i*8 +: 8] : rd_data[i*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/hippo_rsp_fifo.sv
// rtl/hippo_rsp_fifo.sv - 2-entry fall-through response FIFO
module hippo_rsp_fifo
   import hippo_mem_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       push_i,
   input  rsp_t       push_data_i,
   input  logic       pop_i,
   output logic       valid_o,
   output rsp_t       data_o,
   output logic [1:0] count_o
);

   rsp_t [1:0] mem_q, mem_d;
   logic       wr_ptr_q, wr_ptr_d;
   logic       rd_ptr_q, rd_ptr_d;
   logic [1:0] count_q, count_d;
   logic       pop_en, bypass, store, deq;

   always_comb begin
      valid_o  = (count_q != 2'd0) || push_i;
      data_o   = (count_q != 2'd0) ? mem_q[rd_ptr_q] : push_data_i;
      pop_en   = pop_i && valid_o;
      // An empty FIFO hands a same-cycle push straight to the consumer.
      bypass   = (count_q == 2'd0) && pop_en;
      store    = push_i && !bypass;
      deq      = pop_en && (count_q != 2'd0);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (store) begin
         mem_d[wr_ptr_q] = push_data_i;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (deq) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, store} - {1'b0, deq};
   end

   assign count_o = count_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q    <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/hippo_mem_ctrl.sv
// rtl/hippo_mem_ctrl.sv - request/response front-end with RMW for partial writes to a single-port BRAM
module hippo_mem_ctrl
   import hippo_mem_pkg::*;
#(
   parameter int DATA_WIDTH = RSP_DW,
   parameter int DEPTH      = 1024,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     req_valid_i,
   output logic                     req_ready_o,
   input  logic                     req_we_i,
   input  logic [ADDR_WIDTH-1:0]    req_addr_i,
   input  logic [DATA_WIDTH/8-1:0]  req_be_i,
   input  logic [DATA_WIDTH-1:0]    req_wdata_i,
   output logic                     rsp_valid_o,
   input  logic                     rsp_ready_i,
   output logic [DATA_WIDTH-1:0]    rsp_rdata_o,
   output logic                     rsp_err_o,
   output logic [$clog2(DEPTH)-1:0] mem_addr_o,
   output logic                     mem_we_o,
   output logic [DATA_WIDTH-1:0]    mem_wdata_o,
   input  logic [DATA_WIDTH-1:0]    mem_rdata_i
);

   localparam int MEM_AW = $clog2(DEPTH);
   localparam int OFF_W  = $clog2(DATA_WIDTH/8);
   localparam int BE_W   = DATA_WIDTH/8;

   state_e                state_q, state_d;
   logic                  en_q, en_d;
   logic [MEM_AW-1:0]     idx_q, idx_d;
   logic [BE_W-1:0]       be_q, be_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] merged_q, merged_d;
   logic                  pend_q, pend_d;
   logic                  pend_rd_q, pend_rd_d;
   logic                  pend_err_q, pend_err_d;

   logic [ADDR_WIDTH-1:0] word_idx;
   logic                  err_dec;
   logic                  inflight;
   logic                  accept;
   logic [1:0]            fifo_count;
   logic                  push;
   rsp_t                  push_data;
   rsp_t                  rsp;

   assign word_idx = req_addr_i >> OFF_W;
   assign err_dec  = (req_addr_i[OFF_W-1:0] != '0) || (word_idx >= ADDR_WIDTH'(DEPTH));
   assign inflight = pend_q || (state_q != IDLE);
   // en_q keeps ready low while reset is held and for the first cycle after it.
   assign req_ready_o = en_q && (state_q == IDLE) &&
                        (({1'b0, fifo_count} + {2'b00, inflight}) < 3'd2);
   assign accept = req_valid_i && req_ready_o;

   always_comb begin
      state_d     = state_q;
      en_d        = 1'b1;
      idx_d       = idx_q;
      be_d        = be_q;
      wdata_d     = wdata_q;
      merged_d    = merged_q;
      pend_d      = 1'b0;
      pend_rd_d   = 1'b0;
      pend_err_d  = 1'b0;
      mem_addr_o  = '0;
      mem_we_o    = 1'b0;
      mem_wdata_o = '0;
      push        = pend_q;
      push_data.rdata = pend_rd_q ? mem_rdata_i : '0;
      push_data.err   = pend_err_q;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               pend_d = 1'b1;
               if (err_dec) begin
                  pend_err_d = 1'b1;
               end else if (!req_we_i) begin
                  mem_addr_o = word_idx[MEM_AW-1:0];
                  pend_rd_d  = 1'b1;
               end else if (&req_be_i) begin
                  mem_addr_o  = word_idx[MEM_AW-1:0];
                  mem_we_o    = 1'b1;
                  mem_wdata_o = req_wdata_i;
               end else if (req_be_i != '0) begin
                  // Partial write: issue the read now, ack comes from RMW_WR instead.
                  mem_addr_o = word_idx[MEM_AW-1:0];
                  pend_d     = 1'b0;
                  idx_d      = word_idx[MEM_AW-1:0];
                  be_d       = req_be_i;
                  wdata_d    = req_wdata_i;
                  state_d    = RMW_RD;
               end
            end
         end
         RMW_RD: begin
            mem_addr_o = idx_q;
            merged_d   = byte_merge(wdata_q, mem_rdata_i, be_q);
            state_d    = RMW_WR;
         end
         RMW_WR: begin
            mem_addr_o      = idx_q;
            mem_we_o        = 1'b1;
            mem_wdata_o     = merged_q;
            push            = 1'b1;
            push_data.rdata = '0;
            push_data.err   = 1'b0;
            state_d         = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         en_q       <= 1'b0;
         idx_q      <= '0;
         be_q       <= '0;
         wdata_q    <= '0;
         merged_q   <= '0;
         pend_q     <= 1'b0;
         pend_rd_q  <= 1'b0;
         pend_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         en_q       <= en_d;
         idx_q      <= idx_d;
         be_q       <= be_d;
         wdata_q    <= wdata_d;
         merged_q   <= merged_d;
         pend_q     <= pend_d;
         pend_rd_q  <= pend_rd_d;
         pend_err_q <= pend_err_d;
      end
   end

   hippo_rsp_fifo u_rsp_fifo (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .push_i      (push),
      .push_data_i (push_data),
      .pop_i       (rsp_ready_i),
      .valid_o     (rsp_valid_o),
      .data_o      (rsp),
      .count_o     (fifo_count)
   );

   assign rsp_rdata_o = rsp.rdata;
   assign rsp_err_o   = rsp.err;

endmodule

// File: tb/tb_hippo_mem_ctrl.sv
// tb/tb_hippo_mem_ctrl.sv - randomized scoreboard bench for hippo_mem_ctrl with a behavioural BRAM
module tb_hippo_mem_ctrl;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr;
   logic [3:0]  req_be;
   logic [31:0] req_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;
   logic [9:0]  mem_addr;
   logic        mem_we;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic [31:0] bram [1024];
   logic [31:0] ref_mem [1024];
   exp_t        exp_q[$];

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0, acc_cyc = 0, we_cyc = 0, rsp_cyc = 0;
   int we_cnt = 0, n_rsp = 0, rdy_viol = 0, stall_seen = 0;
   logic [31:0] we_data, rsp_data;
   logic acc, ref_commit, rand_ready;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) bram[mem_addr] <= mem_wdata;
      mem_rdata <= bram[mem_addr];
   end

   hippo_mem_ctrl #(.DATA_WIDTH(32), .DEPTH(1024), .ADDR_WIDTH(32)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_we_i    (req_we),
      .req_addr_i  (req_addr),
      .req_be_i    (req_be),
      .req_wdata_i (req_wdata),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_rdata_o (rsp_rdata),
      .rsp_err_o   (rsp_err),
      .mem_addr_o  (mem_addr),
      .mem_we_o    (mem_we),
      .mem_wdata_o (mem_wdata),
      .mem_rdata_i (mem_rdata)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic we, input logic [31:0] addr,
                                  input logic [3:0] be, input logic [31:0] wd);
      exp_t e;
      int unsigned idx = addr >> 2;
      e.rdata = 32'h0;
      e.err   = 1'b0;
      if (addr[1:0] != 2'b00 || idx >= 1024) begin
         e.err = 1'b1;
      end else if (we) begin
         if (ref_commit)
            for (int b = 0; b < 4; b++)
               if (be[b]) ref_mem[idx][b*8 +: 8] = wd[b*8 +: 8];
      end else begin
         e.rdata = ref_mem[idx];
      end
      return e;
   endfunction

   task automatic sample();
      exp_t e;
      cyc++;
      acc = 1'b0;
      if (!rst_n) return;
      if (mem_we) begin
         we_cnt++;
         we_cyc  = cyc;
         we_data = mem_wdata;
      end
      if (req_ready && exp_q.size() >= 2) rdy_viol++;
      if (req_valid && !req_ready && !rsp_ready) stall_seen++;
      if (rsp_valid && rsp_ready) begin
         rsp_cyc  = cyc;
         rsp_data = rsp_rdata;
         n_rsp++;
         if (exp_q.size() == 0) begin
            check("rsp_unexpected", 64'(rsp_valid), 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
            check("rsp_err", 64'(rsp_err), 64'(e.err));
         end
      end
      if (req_valid && req_ready) begin
         acc     = 1'b1;
         acc_cyc = cyc;
         exp_q.push_back(model(req_we, req_addr, req_be, req_wdata));
      end
   endtask

   task automatic step();
      if (rand_ready) rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
   endtask

   task automatic do_req(input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd);
      logic got = 1'b0;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_be    = be;
      req_wdata = wd;
      for (int i = 0; i < 50 && !got; i++) begin
         step();
         got = acc;
      end
      if (!got) check("req_accept_timeout", 64'd0, 64'd1);
      req_valid = 1'b0;
   endtask

   task automatic drain();
      rand_ready = 1'b0;
      rsp_ready  = 1'b1;
      for (int i = 0; i < 50 && exp_q.size() > 0; i++) step();
      if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_req_ready"}, 64'(req_ready), 64'd0);
      check({pfx, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
      check({pfx, "_mem_we"},    64'(mem_we),    64'd0);
      check({pfx, "_mem_addr"},  64'(mem_addr),  64'd0);
      check({pfx, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
   endtask

   initial begin
      int w0, r0, max_out, n_iss;
      logic [31:0] addr, sw[8];
      logic [3:0]  be;
      int r;

      rst_n = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_be = 4'h0; req_wdata = 32'h0;
      rsp_ready = 1'b1; rand_ready = 1'b0; ref_commit = 1'b1;
      acc = 1'b0; we_data = 32'h0; rsp_data = 32'h0;
      for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;

      // Drive a request into the held-reset DUT: it must stay invisible.
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h44; req_be = 4'hF; req_wdata = 32'h12345678;
      @(negedge clk);
      check_reset_outputs("rst");
      req_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Full write then read, with timing.
      do_req(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
      check("wr_full_we_cycle", 64'(we_cyc - acc_cyc), 64'd0);
      check("wr_full_wdata", 64'(we_data), 64'hDEADBEEF);
      drain();
      do_req(1'b0, 32'h10, 4'h0, 32'h0);
      drain();
      check("rd_latency", 64'(rsp_cyc - acc_cyc), 64'd1);
      check("rd_data", 64'(rsp_data), 64'hDEADBEEF);

      // Partial write via RMW.
      w0 = we_cnt;
      do_req(1'b1, 32'h10, 4'h1, 32'h000000AA);
      drain();
      check("rmw_we_cycle", 64'(we_cyc - acc_cyc), 64'd2);
      check("rmw_wdata", 64'(we_data), 64'hDEADBEAA);
      check("rmw_we_pulses", 64'(we_cnt - w0), 64'd1);
      do_req(1'b0, 32'h10, 4'h0, 32'h0);
      drain();
      check("rmw_readback", 64'(rsp_data), 64'hDEADBEAA);

      // Zero byte-enable write: ack only.
      w0 = we_cnt;
      do_req(1'b1, 32'h10, 4'h0, 32'h55555555);
      drain();
      check("be0_no_we", 64'(we_cnt - w0), 64'd0);

      // Misaligned and out-of-range.
      w0 = we_cnt;
      do_req(1'b0, 32'h2, 4'h0, 32'h0);
      do_req(1'b0, 32'h1000, 4'h0, 32'h0);
      do_req(1'b1, 32'h1004, 4'hF, 32'hFFFFFFFF);
      drain();
      check("err_no_we", 64'(we_cnt - w0), 64'd0);

      // Populate a 16-word window for the rest of the run.
      for (int i = 0; i < 16; i++) do_req(1'b1, 32'h200 + 32'(i * 4), 4'hF, $urandom);
      drain();

      // Streaming reads with a 5-cycle response stall.
      for (int i = 0; i < 8; i++) sw[i] = 32'h200 + 32'($urandom_range(0, 15) * 4);
      r0 = n_rsp; max_out = 0; n_iss = 0; stall_seen = 0;
      for (int c = 0; c < 60 && (n_iss < 8 || exp_q.size() > 0); c++) begin
         req_valid = (n_iss < 8);
         req_we    = 1'b0;
         req_addr  = sw[n_iss < 8 ? n_iss : 7];
         rsp_ready = !(c >= 2 && c < 7);
         step();
         if (acc) n_iss++;
         if (exp_q.size() > max_out) max_out = exp_q.size();
      end
      req_valid = 1'b0;
      check("stream_issued", 64'(n_iss), 64'd8);
      check("stream_rsp_count", 64'(n_rsp - r0), 64'd8);
      check("stream_max_pending", 64'(max_out), 64'd2);
      check("stream_ready_dropped", 64'(stall_seen > 0), 64'd1);

      // Random mix under random backpressure.
      rand_ready = 1'b1;
      for (int n = 0; n < 300; n++) begin
         r    = $urandom_range(0, 99);
         addr = 32'h200 + 32'($urandom_range(0, 15) * 4);
         if (r < 8)       addr = addr + 32'($urandom_range(1, 3));
         else if (r < 13) addr = 32'h1000 + 32'($urandom_range(0, 255) * 4);
         else if (r < 15) addr = 32'hFFFF_FFF0;
         be = 4'($urandom);
         if ($urandom_range(0, 3) == 0) be = 4'hF;
         if ($urandom_range(0, 9) == 0) be = 4'h0;
         do_req(1'($urandom), addr, be, $urandom);
         if ($urandom_range(0, 3) == 0) step();
      end
      drain();

      // Reset during RMW_RD must leave the word untouched.
      ref_commit = 1'b0;
      do_req(1'b1, 32'h200, 4'h3, 32'hAABBCCDD);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrmw");
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      ref_commit = 1'b1;
      do_req(1'b0, 32'h200, 4'h0, 32'h0);
      drain();
      check("midrmw_word", 64'(rsp_data), 64'(ref_mem[128]));

      check("ready_gate_violations", 64'(rdy_viol), 64'd0);
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
